// File: rtl/tinyalu_rr_arbiter.sv
// rtl/tinyalu_rr_arbiter.sv - round-robin arbiter sharing one TinyALU among NUM_REQ requesters
module tinyalu_rr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_a,
    input  logic [8*NUM_REQ-1:0]   req_b,
    input  logic [3*NUM_REQ-1:0]   req_op,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   rsp_valid,
    output logic [2:0]             rsp_id,
    output logic [15:0]            rsp_result,
    output logic                   rsp_err,
    output logic                   start,
    output logic [7:0]             A,
    output logic [7:0]             B,
    output logic [2:0]             op,
    input  logic                   done,
    input  logic [15:0]            result
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_GAP
    } state_t;

    state_t             state_q;
    logic [2:0]         last_q;
    logic [2:0]         grant_q;
    logic [CW-1:0]      cnt_q;
    logic [NUM_REQ-1:0] ack_q;
    logic               rsp_valid_q;
    logic [2:0]         rsp_id_q;
    logic [15:0]        rsp_result_q;
    logic               rsp_err_q;
    logic               start_q;
    logic [7:0]         a_q;
    logic [7:0]         b_q;
    logic [2:0]         op_q;

    logic               win_found;
    logic [2:0]         win_id;
    logic [7:0]         win_a;
    logic [7:0]         win_b;
    logic [2:0]         win_op;

    // Round-robin pick: first requester above last, else first at or below last,
    // then mux out the winner's operands.
    always_comb begin
        win_found = 1'b0;
        win_id    = 3'd0;
        win_a     = 8'd0;
        win_b     = 8'd0;
        win_op    = 3'd0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!win_found && req[j] && (j > int'(last_q))) begin
                win_found = 1'b1;
                win_id    = 3'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!win_found && req[j] && (j <= int'(last_q))) begin
                win_found = 1'b1;
                win_id    = 3'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (3'(j) == win_id) begin
                win_a  = req_a[8*j +: 8];
                win_b  = req_b[8*j +: 8];
                win_op = req_op[3*j +: 3];
            end
        end
    end

    // Arbitration FSM with registered ALU handshake and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_q       <= 3'(NUM_REQ - 1);
            grant_q      <= 3'd0;
            cnt_q        <= '0;
            ack_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 3'd0;
            rsp_result_q <= 16'h0000;
            rsp_err_q    <= 1'b0;
            start_q      <= 1'b0;
            a_q          <= 8'd0;
            b_q          <= 8'd0;
            op_q         <= 3'd0;
        end else begin
            ack_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        grant_q <= win_id;
                        last_q  <= win_id;
                        a_q     <= win_a;
                        b_q     <= win_b;
                        op_q    <= win_op;
                        cnt_q   <= '0;
                        if (win_op != 3'd0) begin
                            start_q <= 1'b1;
                            state_q <= S_BUSY;
                        end else begin
                            // no_op completes without touching the ALU
                            ack_q        <= ONE_HOT0 << win_id;
                            rsp_valid_q  <= 1'b1;
                            rsp_id_q     <= win_id;
                            rsp_result_q <= 16'h0000;
                            state_q      <= S_GAP;
                        end
                    end
                end
                S_BUSY: begin
                    if (done) begin
                        start_q      <= 1'b0;
                        ack_q        <= ONE_HOT0 << grant_q;
                        rsp_valid_q  <= 1'b1;
                        rsp_id_q     <= grant_q;
                        rsp_result_q <= result;
                        state_q      <= S_GAP;
                    end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        // watchdog abort: answer the requester with an error
                        start_q      <= 1'b0;
                        ack_q        <= ONE_HOT0 << grant_q;
                        rsp_valid_q  <= 1'b1;
                        rsp_err_q    <= 1'b1;
                        rsp_id_q     <= grant_q;
                        rsp_result_q <= 16'h0000;
                        state_q      <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack        = ack_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign start      = start_q;
    assign A          = a_q;
    assign B          = b_q;
    assign op         = op_q;

endmodule

// File: tb/tb_tinyalu_rr_arbiter.sv
// tb/tb_tinyalu_rr_arbiter.sv - self-checking bench for tinyalu_rr_arbiter
module tb_tinyalu_rr_arbiter;

    localparam int N = 4;
    localparam int T = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [N-1:0]     req;
    logic [8*N-1:0]   req_a;
    logic [8*N-1:0]   req_b;
    logic [3*N-1:0]   req_op;
    logic [N-1:0]     ack;
    logic             rsp_valid;
    logic [2:0]       rsp_id;
    logic [15:0]      rsp_result;
    logic             rsp_err;
    logic             start;
    logic [7:0]       A;
    logic [7:0]       B;
    logic [2:0]       op;
    logic             done;
    logic [15:0]      result;

    int compared = 0;
    int mismatched = 0;

    tinyalu_rr_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .ack(ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .start(start), .A(A), .B(B),
        .op(op), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] o);
        case (o)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    // Stand-in ALU: done during the alu_lat-th cycle of start (alu_lat=0: never)
    int   alu_lat = 1;
    int   alu_cnt = 0;
    logic stray_done = 1'b0;
    always @(posedge clk) alu_cnt <= (start === 1'b1) ? alu_cnt + 1 : 0;
    assign done   = ((start === 1'b1) && alu_lat > 0 && alu_cnt == alu_lat - 1) || stray_done;
    assign result = alu_fn(A, B, op);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: predicts outputs from grant time and ALU latency
    logic [N-1:0] m_ack;
    logic         m_valid, m_err, m_start;
    logic [2:0]   m_id, m_op;
    logic [15:0]  m_res, t_res;
    logic [7:0]   m_a, m_b;
    logic         t_err, active;
    int           m_last, gid, tc, free_at, edge_n;

    task automatic m_reset();
        m_ack = '0; m_valid = 0; m_err = 0; m_start = 0; m_id = 0; m_res = 0;
        m_a = 0; m_b = 0; m_op = 0; m_last = N - 1; active = 0;
        free_at = 0; edge_n = 0; gid = 0; tc = 0; t_res = 0; t_err = 0;
    endtask

    task automatic m_step();
        int w, idx;
        edge_n++;
        m_ack = '0; m_valid = 0; m_err = 0;
        if (active) begin
            if (edge_n == tc) begin
                m_start = 0; m_ack[gid] = 1'b1; m_valid = 1; m_err = t_err;
                m_id = 3'(gid); m_res = t_err ? 16'h0000 : t_res;
                active = 0; free_at = edge_n + 2;
            end
        end else if (edge_n >= free_at && req != '0) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (w < 0 && req[idx]) w = idx;
            end
            m_last = w; gid = w;
            m_a = req_a[8*w +: 8]; m_b = req_b[8*w +: 8]; m_op = req_op[3*w +: 3];
            if (m_op == 3'd0) begin
                m_ack[w] = 1'b1; m_valid = 1; m_id = 3'(w); m_res = 16'h0000;
                free_at = edge_n + 2;
            end else begin
                active = 1; m_start = 1; t_res = alu_fn(m_a, m_b, m_op);
                if (alu_lat >= 1 && alu_lat <= T) begin
                    tc = edge_n + alu_lat; t_err = 0;
                end else begin
                    tc = edge_n + T; t_err = 1;
                end
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) m_reset();
            else m_step();
        end
    end

    // Compare DUT against the model every cycle
    initial begin
        forever begin
            @(negedge clk);
            chk("start", start, m_start);
            chk("ack", ack, m_ack);
            chk("rsp_valid", rsp_valid, m_valid);
            chk("rsp_err", rsp_err, m_err);
            chk("A", A, m_a);
            chk("B", B, m_b);
            chk("op", op, m_op);
            chk("ack_onehot0", 32'($onehot0(ack)), 1);
            if (m_valid) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_result", rsp_result, m_res);
            end
        end
    end

    // Start activity monitor
    int   cyc = 0;
    int   start_hi = 0;
    logic prev_start = 1'b0;
    int   rises[$];
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (start === 1'b1) begin
                start_hi++;
                if (!prev_start) rises.push_back(cyc);
            end
            prev_start = (start === 1'b1);
        end
    end

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] o);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
        req_op[3*i +: 3] = o;
    endtask

    task automatic wait_ack(output int id, output logic [15:0] r, output logic e);
        bit got = 0;
        id = -1; r = 16'hDEAD; e = 1'b1;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                got = 1; id = int'(rsp_id); r = rsp_result; e = rsp_err;
            end
        end
        if (!got) begin
            compared++; mismatched++;
            $display("FAIL ack_wait: got no rsp_valid expected one within 80 cycles (t=%0t)", $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    int          id;
    logic [15:0] r;
    logic        e;
    int          exp_ord[5] = '{0, 1, 2, 3, 0};

    initial begin
        req = '0; req_a = '0; req_b = '0; req_op = '0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_start", start, 0);
        chk("rst_ack", ack, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_A", A, 0);
        reset_n = 1'b1;

        // 1: single add, done one cycle after start
        set_req(0, 8'h05, 8'h03, 3'd1); alu_lat = 1; req = 4'b0001;
        @(negedge clk);
        chk("t1_start", start, 1);
        chk("t1_A", A, 8'h05);
        @(negedge clk);
        chk("t1_ack", ack, 4'b0001);
        chk("t1_result", rsp_result, 16'h0008);
        chk("t1_id", rsp_id, 0);
        chk("t1_err", rsp_err, 0);
        chk("t1_start_low", start, 0);
        req = '0;
        @(negedge clk);
        chk("t1_gap_ack", ack, 0);

        // 2: all requesting, round-robin order and issue spacing
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 8'(10 * i + 1), 8'(i + 2), 3'd1);
        rises.delete();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(id, r, e);
            chk("t2_order", id, exp_ord[i]);
        end
        req = '0;
        chk("t2_issues", rises.size(), 5);
        for (int i = 1; i < 5 && i < rises.size(); i++)
            chk("t2_spacing", rises[i] - rises[i-1], 3);

        // 3: wrap-around from last=2
        do_reset();
        req = 4'b0100;
        wait_ack(id, r, e);
        chk("t3_first", id, 2);
        req = 4'b0101;
        wait_ack(id, r, e);
        chk("t3_wrap", id, 0);
        req = 4'b0100;
        wait_ack(id, r, e);
        chk("t3_then", id, 2);
        req = '0;

        // 4: multi-cycle mul
        set_req(1, 8'hFF, 8'hFF, 3'd4); alu_lat = 3; start_hi = 0;
        req = 4'b0010;
        wait_ack(id, r, e);
        req = '0;
        chk("t4_id", id, 1);
        chk("t4_result", r, 16'hFE01);
        chk("t4_err", e, 0);
        chk("t4_start_cycles", start_hi, 3);

        // 5: watchdog timeout, then a normal request
        set_req(2, 8'h02, 8'h03, 3'd4); alu_lat = 0; start_hi = 0;
        req = 4'b0100;
        wait_ack(id, r, e);
        req = '0;
        chk("t5_id", id, 2);
        chk("t5_err", e, 1);
        chk("t5_result", r, 16'h0000);
        chk("t5_start_cycles", start_hi, T);
        set_req(3, 8'hF0, 8'hFF, 3'd3); alu_lat = 1;
        req = 4'b1000;
        wait_ack(id, r, e);
        req = '0;
        chk("t5_next_id", id, 3);
        chk("t5_next_result", r, 16'h000F);
        chk("t5_next_err", e, 0);

        // stray done while idle produces nothing
        @(negedge clk);
        stray_done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stray_done_valid", rsp_valid, 0);
        end
        stray_done = 1'b0;

        // 6: reset during BUSY, then priority and no_op
        set_req(1, 8'h11, 8'h22, 3'd4); alu_lat = 0;
        req = 4'b0010;
        repeat (4) @(negedge clk);
        chk("t6_busy_start", start, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_start", start, 0);
        chk("t6_rst_ack", ack, 0);
        req = '0;
        repeat (2) @(negedge clk);
        set_req(0, 8'h33, 8'h44, 3'd0);
        set_req(1, 8'h10, 8'h20, 3'd1);
        alu_lat = 1; start_hi = 0;
        reset_n = 1'b1;
        req = 4'b0011;
        @(negedge clk);
        chk("t6_noop_valid", rsp_valid, 1);
        chk("t6_noop_ack", ack, 4'b0001);
        chk("t6_noop_result", rsp_result, 16'h0000);
        chk("t6_noop_start", start_hi, 0);
        req = 4'b0010;
        wait_ack(id, r, e);
        req = '0;
        chk("t6_next_id", id, 1);
        chk("t6_next_result", r, 16'h0030);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tinyalu_rr_arbiter.md
Name: tinyalu_rr_arbiter

Overview:
- Shares one TinyALU between NUM_REQ independent requesters using round-robin arbitration.
- Sequences the ALU start/done handshake: holds start and the operands stable until done, then returns the result to the granted requester.
- Enforces one idle gap cycle between operations and a watchdog timeout.
- Sits between the requester-side drivers and the TinyALU DUT. The existing result monitor still observes done/result on the ALU side, unchanged.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 16, max cycles in BUSY before abort (>=4)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester request; held high with operands stable until its ack
req_a  input  8*NUM_REQ  operand A, requester i in bits [8i+7:8i]
req_b  input  8*NUM_REQ  operand B, same packing as req_a
req_op  input  3*NUM_REQ  opcode, requester i in bits [3i+2:3i]
ack  output  NUM_REQ  one-cycle completion pulse to the granted requester
rsp_valid  output  1  one-cycle pulse, coincident with ack
rsp_id  output  3  index of the completing requester
rsp_result  output  16  result for the completing requester
rsp_err  output  1  one-cycle pulse, coincident with ack when the operation timed out
start  output  1  to ALU
A  output  8  to ALU
B  output  8  to ALU
op  output  3  to ALU
done  input  1  from ALU
result  input  16  from ALU

Behaviour:
- All outputs are registered.
- Reset (asynchronous, reset_n low): state=IDLE; ack=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_result=0, start=0, A=0, B=0, op=0; rr pointer last=NUM_REQ-1, so requester 0 has first priority.
- Reset asserted mid-operation: start drops immediately and no ack is issued.

FSM:
- States: IDLE, BUSY, GAP.
- IDLE, no req: remain in IDLE.
- IDLE, any req: winner = first set bit of req searching from (last+1) mod NUM_REQ upward, wrapping. At the next edge, latch grant id, set last=winner, and capture that requester's operands into A/B/op.
  - Winner op != 0: start=1, go to BUSY. start is visible one cycle after req is sampled.
  - Winner op == 0 (no_op): start stays 0; ack[winner]=1, rsp_valid=1, rsp_result=0, go to GAP.
- BUSY: start, A, B, op held constant; watchdog counter increments each cycle from 0.
  - done sampled high: at that edge start=0, rsp_result=result, rsp_id=grant, ack[grant]=1, rsp_valid=1; go to GAP.
  - Counter reaches TIMEOUT_CYCLES-1 without done: start=0, rsp_result=16'h0000, rsp_err=1, ack and rsp_valid pulsed; go to GAP.
- GAP: exactly one cycle. ack, rsp_valid and rsp_err return to 0, start stays 0, req is ignored. Then go to IDLE.
- Minimum issue-to-issue spacing is 3 cycles for single-cycle ALU ops.
- done while not in BUSY is ignored; no response is generated.
- A requester's req must fall the cycle after its ack. If it stays high it is re-eligible but behind all others in rr order.
- Only one ack bit is ever high at a time; ack is one-hot or zero.
- A/B/op retain their last values after completion; they are not cleared.

Test Plan:
1. Reset, req=4'b0001, A=8'h05, B=8'h03, op=add (1), ALU done 1 cycle after start -> start high for 1 cycle, ack=4'b0001, rsp_result=16'h0008, rsp_id=0, rsp_err=0, then 1 GAP cycle.
2. req=4'b1111 held, all op=add -> grants in order 0,1,2,3,0; each issue-to-issue spacing 3 cycles; ack never has more than one bit set.
3. last=2, req=4'b0101 -> requester 0 granted next (wrap-around); requester 2 granted after it.
4. Requester 1 op=mul (4), A=8'hFF, B=8'hFF, done after 3 cycles -> start held 3 cycles with A/B/op stable, rsp_result=16'hFE01.
5. op=mul, done never asserted, TIMEOUT_CYCLES=16 -> start drops after 16 BUSY cycles, rsp_err=1, rsp_result=0, ack pulsed once; next request served normally.
6. reset_n low while in BUSY -> start=0 immediately with no ack. After release, requester 0 has priority. op=0 request -> ack with result 0 next cycle and start never asserted.
